// File: rtl/fas_pkg.sv
// fas_pkg: shared constants and FSM state type for the FFT peak controller.
//   N_BINS : bins per frame
//   HW     : width of one signed 8.8 component
//   MAG_W  : width of an unsigned re^2+im^2 magnitude
//   IDX_W  : width of a bin index
//   state_t: controller states IDLE, SCAN, DONE
package fas_pkg;
   localparam int N_BINS = 16;
   localparam int HW     = 16;
   localparam int MAG_W  = 2*HW + 1;
   localparam int IDX_W  = $clog2(N_BINS);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: combinational squared magnitude of one packed complex bin.
//   bin : {re[HW-1:0], im[HW-1:0]}, signed 8.8 components
//   mag : re*re + im*im, unsigned, full width (16.16)
module fft_mag_sq #(
   parameter int HW = 16
) (
   input  logic [2*HW-1:0] bin,
   output logic [2*HW:0]   mag
);
   logic signed [HW-1:0]   re, im;
   logic signed [2*HW-1:0] re_sq, im_sq;
   assign re    = bin[2*HW-1:HW];
   assign im    = bin[HW-1:0];
   assign re_sq = re * re;
   assign im_sq = im * im;
   // Both squares are non-negative, so zero-extension keeps the carry of the sum.
   assign mag   = {1'b0, re_sq} + {1'b0, im_sq};
endmodule

// File: rtl/fft_peak_ctrl.sv
// fft_peak_ctrl: captures a 16-bin FFT frame and scans it one bin per cycle for the peak magnitude.
//   clk, rst           : clock, synchronous active-high reset
//   fft_d0..fft_d15    : bin data {re, im}, signed 8.8
//   fft_valid          : one-cycle strobe of a complete frame
//   busy               : frame captured and not yet reported
//   done               : one-cycle pulse when freq/peak_mag update
//   freq, peak_mag     : index and magnitude of the strongest bin (lowest index on ties)
//   overrun            : one-cycle pulse when a frame arriving mid-scan is dropped
module fft_peak_ctrl #(
   parameter int N_BINS = 16,
   parameter int HW     = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2*HW-1:0] fft_d0,
   input  logic [2*HW-1:0] fft_d1,
   input  logic [2*HW-1:0] fft_d2,
   input  logic [2*HW-1:0] fft_d3,
   input  logic [2*HW-1:0] fft_d4,
   input  logic [2*HW-1:0] fft_d5,
   input  logic [2*HW-1:0] fft_d6,
   input  logic [2*HW-1:0] fft_d7,
   input  logic [2*HW-1:0] fft_d8,
   input  logic [2*HW-1:0] fft_d9,
   input  logic [2*HW-1:0] fft_d10,
   input  logic [2*HW-1:0] fft_d11,
   input  logic [2*HW-1:0] fft_d12,
   input  logic [2*HW-1:0] fft_d13,
   input  logic [2*HW-1:0] fft_d14,
   input  logic [2*HW-1:0] fft_d15,
   input  logic            fft_valid,
   output logic            busy,
   output logic            done,
   output logic [3:0]      freq,
   output logic [2*HW:0]   peak_mag,
   output logic            overrun
);
   import fas_pkg::*;
   state_t             state, state_nx;
   logic [2*HW-1:0]    din  [N_BINS];
   logic [2*HW-1:0]    bank [N_BINS];
   logic [IDX_W-1:0]   idx, arg;
   logic [MAG_W-1:0]   max_mag, mag;
   logic               capture, last;
   assign din = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
   // A frame is accepted in IDLE and in DONE (back-to-back); in SCAN it is dropped.
   assign capture = fft_valid && state != SCAN;
   assign last    = idx == IDX_W'(N_BINS - 1);
   assign busy    = state != IDLE;
   fft_mag_sq #(.HW(HW)) u_mag (
      .bin(bank[idx]),
      .mag(mag)
   );
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = (state == SCAN) ? (last ? DONE : SCAN) : (fft_valid ? SCAN : IDLE);
   end
   // The bank has no reset; it is always overwritten before a scan reads it.
   always_ff @(posedge clk)
      if (!rst && capture) bank <= din;
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         arg      <= '0;
         max_mag  <= '0;
         done     <= 1'b0;
         overrun  <= 1'b0;
         freq     <= '0;
         peak_mag <= '0;
      end else begin
         done    <= state == DONE;
         overrun <= fft_valid && state == SCAN;
         if (state == DONE) begin
            freq     <= arg;
            peak_mag <= max_mag;
         end
         if (capture) begin
            idx     <= '0;
            arg     <= '0;
            max_mag <= '0;
         end else if (state == SCAN) begin
            idx <= idx + 1'b1;
            // Strictly greater keeps the lower index on ties.
            if (mag > max_mag) begin
               max_mag <= mag;
               arg     <= idx;
            end
         end
      end
   end
endmodule

// File: tb/tb_fft_peak_ctrl.sv
// tb_fft_peak_ctrl: table-driven, hand-sequenced and randomized checks of fft_peak_ctrl.
module tb_fft_peak_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fft_valid = 1'b0;
   logic [31:0] d [16];
   logic        busy, done, overrun;
   logic [3:0]  freq;
   logic [32:0] peak_mag;
   int          n_pass = 0;
   int          n_total = 0;

   typedef struct {
      int          b0;
      logic [31:0] v0;
      int          b1;
      logic [31:0] v1;
      int          b2;
      logic [31:0] v2;
      logic [3:0]  ef;
      logic [32:0] em;
   } vec_t;

   vec_t tbl [6];

   always #5 clk = ~clk;

   fft_peak_ctrl dut (
      .clk(clk), .rst(rst),
      .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
      .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
      .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
      .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
      .fft_valid(fft_valid), .busy(busy), .done(done), .freq(freq),
      .peak_mag(peak_mag), .overrun(overrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [32:0] got, input logic [32:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      else n_pass++;
   endtask

   // Reference: strongest bin by plain integer arithmetic, first index wins ties.
   function automatic void model(input logic [31:0] f [16], output logic [3:0] fr, output logic [32:0] pm);
      longint best;
      best = 0;
      fr = 4'd0;
      for (int k = 0; k < 16; k++) begin
         longint re, im, m;
         re = longint'($signed(f[k][31:16]));
         im = longint'($signed(f[k][15:0]));
         m  = re*re + im*im;
         if (m > best) begin
            best = m;
            fr = 4'(k);
         end
      end
      pm = 33'(best);
   endfunction

   task automatic mk_frame(input vec_t v, output logic [31:0] f [16]);
      for (int k = 0; k < 16; k++) f[k] = 32'h0;
      if (v.b0 >= 0) f[v.b0] = v.v0;
      if (v.b1 >= 0) f[v.b1] = v.v1;
      if (v.b2 >= 0) f[v.b2] = v.v2;
   endtask

   task automatic peak_frame(input int b, output logic [31:0] f [16]);
      for (int k = 0; k < 16; k++) f[k] = 32'h0010_0010;
      f[b] = 32'h0200_0000;
   endtask

   // Full frame: capture edge C, done expected exactly at C+17 and held values afterwards.
   task automatic run_frame(input string nm, input logic [31:0] f [16], input logic [3:0] ef, input logic [32:0] em);
      int early, ovr;
      early = 0;
      ovr = 0;
      d = f;
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      check({nm, "_busy"}, 33'(busy), 33'd1);
      for (int c = 1; c <= 16; c++) begin
         tick();
         early += int'(done);
         ovr += int'(overrun);
      end
      tick();
      check({nm, "_early_done"}, 33'(early), 33'd0);
      check({nm, "_done"}, 33'(done), 33'd1);
      check({nm, "_freq"}, 33'(freq), 33'(ef));
      check({nm, "_mag"}, peak_mag, em);
      check({nm, "_busy_idle"}, 33'(busy), 33'd0);
      tick();
      check({nm, "_done_pulse"}, 33'(done), 33'd0);
      check({nm, "_freq_hold"}, 33'(freq), 33'(ef));
      check({nm, "_no_overrun"}, 33'(ovr), 33'd0);
   endtask

   initial begin
      logic [31:0] f [16];
      logic [31:0] g [16];
      logic [3:0]  ef;
      logic [32:0] em;
      int          cnt, ovr;

      tbl[0] = '{b0:5,  v0:32'h0100_0000, b1:-1, v1:0,               b2:-1, v2:0,               ef:4'd5,  em:33'h0_0001_0000};
      tbl[1] = '{b0:3,  v0:32'h0100_0100, b1:9,  v1:32'h0100_0100,  b2:12, v2:32'hFE00_0000,  ef:4'd12, em:33'h0_0004_0000};
      tbl[2] = '{b0:3,  v0:32'hFF00_0100, b1:9,  v1:32'hFF00_0100,  b2:-1, v2:0,               ef:4'd3,  em:33'h0_0002_0000};
      tbl[3] = '{b0:-1, v0:0,               b1:-1, v1:0,               b2:-1, v2:0,               ef:4'd0,  em:33'h0_0000_0000};
      tbl[4] = '{b0:15, v0:32'h8000_8000, b1:0,  v1:32'h0001_0000,  b2:-1, v2:0,               ef:4'd15, em:33'h0_8000_0000};
      tbl[5] = '{b0:0,  v0:32'h0000_0001, b1:-1, v1:0,               b2:-1, v2:0,               ef:4'd0,  em:33'h0_0000_0001};

      for (int k = 0; k < 16; k++) d[k] = 32'h0100_0100;
      fft_valid = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      fft_valid = 1'b0;
      check("rst_busy", 33'(busy), 33'd0);
      check("rst_done", 33'(done), 33'd0);
      check("rst_overrun", 33'(overrun), 33'd0);
      check("rst_freq", 33'(freq), 33'd0);
      check("rst_mag", peak_mag, 33'd0);
      tick();
      check("rst_valid_ignored", 33'(busy), 33'd0);

      for (int i = 0; i < 6; i++) begin
         mk_frame(tbl[i], f);
         run_frame($sformatf("tbl%0d", i), f, tbl[i].ef, tbl[i].em);
      end

      // Overrun: frame B arrives at C+5 and must be dropped.
      peak_frame(7, f);
      peak_frame(2, g);
      d = f;
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      for (int c = 1; c <= 4; c++) tick();
      d = g;
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      check("ovr_pulse", 33'(overrun), 33'd1);
      tick();
      check("ovr_pulse_end", 33'(overrun), 33'd0);
      cnt = 0;
      for (int c = 7; c <= 16; c++) begin
         tick();
         cnt += int'(done);
      end
      tick();
      check("ovr_early_done", 33'(cnt), 33'd0);
      check("ovr_done", 33'(done), 33'd1);
      check("ovr_freq", 33'(freq), 33'd7);
      cnt = 0;
      for (int c = 0; c < 25; c++) begin
         tick();
         cnt += int'(done);
      end
      check("ovr_no_second_done", 33'(cnt), 33'd0);

      // Back-to-back: B presented during A's DONE cycle.
      peak_frame(2, f);
      peak_frame(14, g);
      ovr = 0;
      d = f;
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         ovr += int'(overrun);
      end
      d = g;
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      ovr += int'(overrun);
      check("b2b_done_a", 33'(done), 33'd1);
      check("b2b_freq_a", 33'(freq), 33'd2);
      check("b2b_busy_b", 33'(busy), 33'd1);
      for (int c = 18; c <= 33; c++) begin
         tick();
         ovr += int'(overrun);
      end
      tick();
      ovr += int'(overrun);
      check("b2b_done_b", 33'(done), 33'd1);
      check("b2b_freq_b", 33'(freq), 33'd14);
      check("b2b_no_overrun", 33'(ovr), 33'd0);

      // Reset mid-scan aborts the frame.
      peak_frame(9, f);
      d = f;
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
      for (int c = 1; c <= 7; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busy", 33'(busy), 33'd0);
      check("mid_rst_freq", 33'(freq), 33'd0);
      check("mid_rst_mag", peak_mag, 33'd0);
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         cnt += int'(done);
      end
      check("mid_rst_no_done", 33'(cnt), 33'd0);
      mk_frame(tbl[1], f);
      run_frame("after_rst", f, tbl[1].ef, tbl[1].em);

      // Randomized frames, including forced ties and small magnitudes.
      for (int r = 0; r < 40; r++) begin
         int a, b;
         for (int k = 0; k < 16; k++)
            f[k] = ($urandom_range(0, 3) == 0) ? {16'($signed(8'($urandom))), 16'($signed(8'($urandom)))} : $urandom;
         if (r % 8 == 7) for (int k = 0; k < 16; k++) f[k] = 32'h0;
         a = $urandom_range(0, 7);
         b = $urandom_range(8, 15);
         if (r % 3 == 0) f[b] = f[a];
         if (r % 5 == 0) f[b] = {f[a][15:0], f[a][31:16]};
         model(f, ef, em);
         run_frame($sformatf("rnd%0d", r), f, ef, em);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
